// File: rtl/haar_cascade_engine_pkg.sv
// rtl/haar_cascade_engine_pkg.sv - shared types, default widths and saturating add for the Haar cascade engine
package haar_pkg;

  localparam int HAAR_DATA_W   = 16;
  localparam int HAAR_WEIGHT_W = 8;
  localparam int HAAR_ACC_W    = 24;

  typedef logic signed [HAAR_ACC_W-1:0]                acc_t;
  typedef logic signed [HAAR_DATA_W+HAAR_WEIGHT_W-1:0] prod_t;

  typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_t;

  // Operands are sign-extended into 64 bits and assumed to fit the w-bit signed range,
  // so the 64-bit sum never overflows and only the w-bit clamp matters.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    s     = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (s > max_v)      return max_v;
    else if (s < min_v) return min_v;
    else                return s;
  endfunction

endpackage

// File: rtl/haar_cascade_engine_if.sv
// rtl/haar_cascade_engine_if.sv - rectangle-beat input stream, result stream and error flag of the cascade engine
interface haar_cascade_engine_if #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_W     = 16,
  parameter int WEIGHT_W   = 8,
  parameter int ACC_W      = 24
);
  localparam int STAGE_W = $clog2(NUM_STAGES + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   rect_sum;
  logic signed [WEIGHT_W-1:0] rect_weight;
  logic                       rect_last;
  logic                       clf_last;
  logic                       win_last;
  logic signed [ACC_W-1:0]    clf_thresh;
  logic signed [ACC_W-1:0]    clf_left;
  logic signed [ACC_W-1:0]    clf_right;
  logic signed [ACC_W-1:0]    stage_thresh;
  logic                       result_valid;
  logic                       result_ready;
  logic                       result_detected;
  logic [STAGE_W-1:0]         result_stages;
  logic                       proto_err;

  modport master (
    output in_valid, rect_sum, rect_weight, rect_last, clf_last, win_last,
           clf_thresh, clf_left, clf_right, stage_thresh, result_ready,
    input  in_ready, result_valid, result_detected, result_stages, proto_err
  );

  modport slave (
    input  in_valid, rect_sum, rect_weight, rect_last, clf_last, win_last,
           clf_thresh, clf_left, clf_right, stage_thresh, result_ready,
    output in_ready, result_valid, result_detected, result_stages, proto_err
  );

endinterface

// File: rtl/haar_cascade_engine_weak_classifier.sv
// rtl/haar_cascade_engine_weak_classifier.sv - feature accumulator and left/right select; HAAR_CASCADE_SATURATE_EN saturates the feature add
module haar_weak_classifier
  import haar_pkg::*;
#(
  parameter int DATA_W   = HAAR_DATA_W,
  parameter int WEIGHT_W = HAAR_WEIGHT_W,
  parameter int ACC_W    = HAAR_ACC_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       accum_en,
  input  logic                       clear,
  input  logic signed [DATA_W-1:0]   rect_sum,
  input  logic signed [WEIGHT_W-1:0] rect_weight,
  input  logic signed [ACC_W-1:0]    clf_thresh,
  input  logic signed [ACC_W-1:0]    clf_left,
  input  logic signed [ACC_W-1:0]    clf_right,
  output logic signed [ACC_W-1:0]    contrib
);

  logic signed [DATA_W+WEIGHT_W-1:0] prod;
  logic signed [ACC_W-1:0]           prod_ext;
  logic signed [ACC_W-1:0]           feat_acc;
  logic signed [ACC_W-1:0]           full_feature;

  assign prod     = rect_sum * rect_weight;
  assign prod_ext = ACC_W'(prod);

`ifdef HAAR_CASCADE_SATURATE_EN
  assign full_feature = ACC_W'(sat_add(64'(feat_acc), 64'(prod_ext), ACC_W));
`else
  assign full_feature = feat_acc + prod_ext;
`endif

  // Only meaningful on a rect_last beat, where it includes that beat's product.
  assign contrib = (full_feature < clf_thresh) ? clf_left : clf_right;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         feat_acc <= '0;
    else if (clear)    feat_acc <= '0;
    else if (accum_en) feat_acc <= full_feature;
  end

endmodule

// File: rtl/haar_cascade_engine.sv
// rtl/haar_cascade_engine.sv - multi-stage Haar cascade evaluator with early exit; HAAR_CASCADE_SATURATE_EN saturates the stage add
module haar_cascade_engine
  import haar_pkg::*;
#(
  parameter int NUM_STAGES      = 4,
  parameter int MAX_CLASSIFIERS = 16,
  parameter int MAX_RECTANGLES  = 4,
  parameter int DATA_W          = HAAR_DATA_W,
  parameter int WEIGHT_W        = HAAR_WEIGHT_W,
  parameter int ACC_W           = HAAR_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  haar_cascade_engine_if.slave   bus
);

  localparam int STAGE_W = $clog2(NUM_STAGES + 1);
  localparam int RECT_W  = $clog2(MAX_RECTANGLES + 1);
  localparam int CLF_W   = $clog2(MAX_CLASSIFIERS + 1);
  localparam logic [STAGE_W-1:0] STAGES_FULL = STAGE_W'(NUM_STAGES);
  localparam logic [RECT_W-1:0]  RECT_MAX    = RECT_W'(MAX_RECTANGLES);
  localparam logic [CLF_W-1:0]   CLF_MAX     = CLF_W'(MAX_CLASSIFIERS);

  state_t                  state_q, state_d;
  logic                    fire, scoring, clf_end, stage_pass, stage_inc, err_now;
  logic signed [ACC_W-1:0] contrib, stage_acc, stage_sum;
  logic [STAGE_W-1:0]      stages_cnt, stages_next, clf_seen, res_stages;
  logic [RECT_W-1:0]       rect_cnt;
  logic [CLF_W-1:0]        clf_cnt;
  logic                    res_detected, proto_err_q;

  assign bus.in_ready        = (state_q != RESULT);
  assign bus.result_valid    = (state_q == RESULT);
  assign bus.result_detected = res_detected;
  assign bus.result_stages   = res_stages;
  assign bus.proto_err       = proto_err_q;

  assign fire    = bus.in_valid && bus.in_ready;
  assign scoring = fire && (state_q == ACCUM);
  assign clf_end = bus.rect_last && bus.clf_last;

  haar_weak_classifier #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_weak (
    .clk         (clk),
    .reset       (reset),
    .accum_en    (scoring),
    .clear       (fire && (bus.rect_last || bus.win_last)),
    .rect_sum    (bus.rect_sum),
    .rect_weight (bus.rect_weight),
    .clf_thresh  (bus.clf_thresh),
    .clf_left    (bus.clf_left),
    .clf_right   (bus.clf_right),
    .contrib     (contrib)
  );

`ifdef HAAR_CASCADE_SATURATE_EN
  assign stage_sum = ACC_W'(sat_add(64'(stage_acc), 64'(contrib), ACC_W));
`else
  assign stage_sum = stage_acc + contrib;
`endif

  assign stage_pass  = (stage_sum >= bus.stage_thresh);
  assign stage_inc   = scoring && clf_end && stage_pass && (stages_cnt < STAGES_FULL);
  assign stages_next = stages_cnt + STAGE_W'(stage_inc);

  assign err_now = (!bus.rect_last && rect_cnt >= RECT_MAX)
                || (bus.rect_last && !bus.clf_last && clf_cnt >= CLF_MAX)
                || (bus.win_last && !clf_end)
                || (clf_end && clf_seen >= STAGES_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (fire && bus.win_last)                 state_d = RESULT;
        else if (fire && clf_end && !stage_pass)  state_d = DRAIN;
      end
      DRAIN:   if (fire && bus.win_last) state_d = RESULT;
      RESULT:  if (bus.result_ready)     state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Window bookkeeping is cleared on the win_last beat; the result registers hold the outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_acc    <= '0;
      stages_cnt   <= '0;
      clf_seen     <= '0;
      rect_cnt     <= '0;
      clf_cnt      <= '0;
      res_stages   <= '0;
      res_detected <= 1'b0;
      proto_err_q  <= 1'b0;
    end else if (fire) begin
      if (err_now) proto_err_q <= 1'b1;
      if (bus.win_last) begin
        stage_acc    <= '0;
        stages_cnt   <= '0;
        clf_seen     <= '0;
        rect_cnt     <= '0;
        clf_cnt      <= '0;
        res_stages   <= stages_next;
        res_detected <= (stages_next == STAGES_FULL);
      end else begin
        if (bus.rect_last)           rect_cnt <= '0;
        else if (rect_cnt != RECT_MAX) rect_cnt <= rect_cnt + 1'b1;
        if (clf_end)                 clf_cnt <= '0;
        else if (bus.rect_last && clf_cnt != CLF_MAX) clf_cnt <= clf_cnt + 1'b1;
        if (clf_end && clf_seen != STAGES_FULL) clf_seen <= clf_seen + 1'b1;
        if (state_q == ACCUM) begin
          if (clf_end)            stage_acc <= '0;
          else if (bus.rect_last) stage_acc <= stage_sum;
          stages_cnt <= stages_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_haar_cascade_engine.sv
// tb/tb_haar_cascade_engine.sv - directed-vector bench for haar_cascade_engine (NUM_STAGES=2); HAAR_CASCADE_SATURATE_EN selects the overflow expectation
module tb_haar_cascade_engine;

  localparam int NS    = 2;
  localparam int ACC_W = 24;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  haar_cascade_engine_if #(.NUM_STAGES(NS)) bus ();

  haar_cascade_engine #(.NUM_STAGES(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic send_beat(input int s, input int w, input bit rl, input bit cl, input bit wl,
                           input int thr, input int lf, input int rt, input int sth);
    int guard;
    bus.rect_sum     = 16'(s);
    bus.rect_weight  = 8'(w);
    bus.rect_last    = rl;
    bus.clf_last     = cl;
    bus.win_last     = wl;
    bus.clf_thresh   = ACC_W'(thr);
    bus.clf_left     = ACC_W'(lf);
    bus.clf_right    = ACC_W'(rt);
    bus.stage_thresh = ACC_W'(sth);
    bus.in_valid     = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("beat_accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input int exp_stages, input bit exp_det);
    check({tag, "_valid"},    32'(bus.result_valid),    32'd1);
    check({tag, "_stages"},   32'(bus.result_stages),   32'(exp_stages));
    check({tag, "_detected"}, 32'(bus.result_detected), 32'(exp_det));
    check({tag, "_in_ready_low"}, 32'(bus.in_ready),    32'd0);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(bus.in_ready),   32'd1);
    check({tag, "_valid_after"},    32'(bus.result_valid), 32'd0);
  endtask

  // Stage 0: feature -10+12=2 < 5 -> +40 >= 30 pass. Stage 1: 200 >= 50 -> right.
  task automatic window_stage0_pass();
    send_beat(10, -1, 0, 0, 0, 0, 0, 0, 0);
    send_beat(4, 3, 1, 1, 0, 5, 40, -10, 30);
  endtask

  task automatic window_full_pass();
    window_stage0_pass();
    send_beat(100, 2, 1, 1, 1, 50, 0, 20, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.result_ready = 1'b0;
    bus.rect_sum = '0; bus.rect_weight = '0;
    bus.rect_last = 1'b0; bus.clf_last = 1'b0; bus.win_last = 1'b0;
    bus.clf_thresh = '0; bus.clf_left = '0; bus.clf_right = '0; bus.stage_thresh = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),        32'd1);
    check("rst_valid",     32'(bus.result_valid),    32'd0);
    check("rst_detected",  32'(bus.result_detected), 32'd0);
    check("rst_stages",    32'(bus.result_stages),   32'd0);
    check("rst_proto_err", 32'(bus.proto_err),       32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Pass then fail on the last stage.
    window_stage0_pass();
    send_beat(100, 2, 1, 1, 1, 50, 0, -20, 0);
    take_result("pass_fail", 1, 1'b0);

    // Both stages pass.
    window_stage0_pass();
    check("mid_window_in_ready", 32'(bus.in_ready), 32'd1);
    send_beat(100, 2, 1, 1, 1, 50, 0, 20, 0);
    take_result("full_pass", 2, 1'b1);

    // Stage 0 fails (12 >= 5 -> +10 < 30), then five discarded beats.
    send_beat(4, 3, 1, 1, 0, 5, 40, 10, 30);
    check("drain_in_ready", 32'(bus.in_ready), 32'd1);
    send_beat(1000, 100, 0, 0, 0, 0, 0, 0, 0);
    send_beat(-500, 7, 0, 0, 0, 0, 0, 0, 0);
    send_beat(3, 3, 0, 0, 0, 0, 0, 0, 0);
    send_beat(9, 9, 0, 0, 0, 0, 0, 0, 0);
    check("drain_no_early_result", 32'(bus.result_valid), 32'd0);
    send_beat(1, 1, 1, 1, 1, 0, 500, 500, 0);
    take_result("early_exit", 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("early_exit_single_result", 32'(bus.result_valid), 32'd0);
    end
    check("early_exit_no_proto_err", 32'(bus.proto_err), 32'd0);

    // Backpressure: result held for four cycles.
    window_full_pass();
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", 32'(bus.in_ready),        32'd0);
      check("bp_stages",   32'(bus.result_stages),   32'd2);
      check("bp_detected", 32'(bus.result_detected), 32'd1);
      @(posedge clk);
      #1;
    end
    take_result("backpressure", 2, 1'b1);

    // Overflow: 8000000 + 8000000 either clamps to 2^23-1 (pass) or wraps negative (fail).
    send_beat(1, 1, 1, 0, 0, 100, 8000000, 0, 0);
    send_beat(1, 1, 1, 1, 1, 100, 8000000, 0, 8388607);
`ifdef HAAR_CASCADE_SATURATE_EN
    take_result("overflow_sat", 1, 1'b0);
`else
    take_result("overflow_wrap", 0, 1'b0);
`endif

    // Five beats without rect_last: sticky protocol error, window still completes.
    for (int i = 0; i < 4; i++) send_beat(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("proto_not_yet", 32'(bus.proto_err), 32'd0);
    send_beat(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("proto_set", 32'(bus.proto_err), 32'd1);
    send_beat(1, 1, 1, 1, 1, 100, 50, 0, 0);
    take_result("proto_window", 1, 1'b0);
    window_full_pass();
    take_result("after_proto", 2, 1'b1);
    check("proto_sticky", 32'(bus.proto_err), 32'd1);

    // Reset mid-window discards partial feature.
    send_beat(50, 1, 0, 0, 0, 0, 0, 0, 0);
    send_beat(50, 1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    check("midrst_proto_err", 32'(bus.proto_err),    32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),     32'd1);
    check("midrst_valid",     32'(bus.result_valid), 32'd0);
    check("midrst_stages",    32'(bus.result_stages), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    window_full_pass();
    take_result("after_reset", 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
